// File: rtl/series_fifo_engine.sv
// Truncated power-series engine (geometric or exponential) feeding a small result FIFO.
// One series term is accumulated per clock. A finished result waits while the FIFO is
// full, so results are never dropped.
module series_fifo_engine #(
    parameter int unsigned FRAC_W = 16,
    parameter int unsigned INT_W  = 5,
    parameter int unsigned TERMS  = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      mode,
    input  logic [FRAC_W-1:0]         x,
    input  logic                      rdreq,
    output logic                      busy,
    output logic                      done,
    output logic                      full,
    output logic                      empty,
    output logic [INT_W+FRAC_W-1:0]   q,
    output logic [$clog2(DEPTH)-1:0]  usedw
);

    localparam int unsigned PW   = FRAC_W + 1;       // Q1.FRAC_W power / coefficient width
    localparam int unsigned MW   = PW + FRAC_W;      // product width before the shift
    localparam int unsigned RW   = INT_W + FRAC_W;   // result width
    localparam int unsigned AccW = RW + 5;           // headroom for up to 16 terms
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [PW-1:0] One   = {1'b1, {FRAC_W{1'b0}}};
    localparam logic [3:0]    KLast = 4'(TERMS - 1);

    // floor(2^FRAC_W / k!) for k = 0..15, packed so entry k sits at bits [k*PW +: PW].
    function automatic logic [16*PW-1:0] gen_coef_rom();
        logic [16*PW-1:0] rom;
        logic [63:0]      fact;
        rom  = '0;
        fact = 64'd1;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) fact = fact * 64'(k);
            rom[k*PW +: PW] = PW'((64'd1 << FRAC_W) / fact);
        end
        return rom;
    endfunction

    localparam logic [16*PW-1:0] CoefRom = gen_coef_rom();

    typedef enum logic [1:0] {StIdle, StCalc, StWait, StPush} state_e;

    state_e              state_q, state_d;
    logic                start_q;
    logic                mode_q, mode_d;
    logic [FRAC_W-1:0]   x_q, x_d;
    logic [3:0]          k_q, k_d;
    logic [PW-1:0]       p_q, p_d;
    logic [AccW-1:0]     acc_q, acc_d;

    logic [RW-1:0]       mem_q [DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]       q_q, q_d;

    logic                launch, push, pop;
    logic [PW-1:0]       coef, p_next, term;
    logic [MW-1:0]       p_prod, t_prod;
    logic [RW-1:0]       wr_data;

    assign launch = (state_q == StIdle) && start && !start_q;
    assign push   = (state_q == StPush);
    assign pop    = rdreq && !empty;

    assign full   = (cnt_q == CntW'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign usedw  = cnt_q[PtrW-1:0];
    assign q      = q_q;
    assign busy   = (state_q != StIdle);
    assign done   = push;

    // Term datapath: next power of x and the coefficient-weighted current term.
    always_comb begin
        coef   = mode_q ? CoefRom[k_q*PW +: PW] : One;
        p_prod = {{FRAC_W{1'b0}}, p_q} * {{PW{1'b0}}, x_q};
        t_prod = {{FRAC_W{1'b0}}, p_q} * {{FRAC_W{1'b0}}, coef};
        p_next = PW'(p_prod >> FRAC_W);
        term   = PW'(t_prod >> FRAC_W);
        // Anything beyond the result range clamps to all ones.
        wr_data = (|acc_q[AccW-1:RW]) ? '1 : acc_q[RW-1:0];
    end

    // Next-state logic for the engine FSM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (launch) state_d = StCalc;
            StCalc: if (k_q == KLast) state_d = full ? StWait : StPush;
            // A pop while full frees a slot at this edge; the write happens next cycle.
            StWait: if (!full || rdreq) state_d = StPush;
            StPush: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Operand capture at launch and per-term accumulation during CALC.
    always_comb begin
        mode_d = mode_q;
        x_d    = x_q;
        k_d    = k_q;
        p_d    = p_q;
        acc_d  = acc_q;
        if (launch) begin
            mode_d = mode;
            x_d    = x;
            k_d    = '0;
            p_d    = One;
            acc_d  = '0;
        end else if (state_q == StCalc) begin
            k_d   = k_q + 4'd1;
            p_d   = p_next;
            acc_d = acc_q + AccW'(term);
        end
    end

    // FIFO pointer, occupancy and read-register next state.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        q_d      = pop ? mem_q[rd_ptr_q] : q_q;
        cnt_d    = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            start_q  <= 1'b0;
            mode_q   <= 1'b0;
            x_q      <= '0;
            k_q      <= '0;
            p_q      <= '0;
            acc_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            q_q      <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start;
            mode_q   <= mode_d;
            x_q      <= x_d;
            k_q      <= k_d;
            p_q      <= p_d;
            acc_q    <= acc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            q_q      <= q_d;
        end
    end

    // FIFO storage; contents are only observed through valid pops, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule
